// File: rtl/alu_pipe.sv
// alu_pipe -- two-stage pipelined ALU with valid/ready handshaking on both sides.
//
// Stage 1 captures the operands and opcode of an accepted operation. Stage 2
// holds the computed Result and NZVC flags until the consumer takes them.
//
// Optional feature macro: ALU_CARRY_CHAIN_EN
//   defined   : opcodes 8 (ADC) and 9 (SBC) use the carry register Cq.
//   undefined : opcodes 8 and 9 behave as reserved and there is no Cq register.
//
// Ports
//   clk        in   1      clock; all state changes on the rising edge
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      operation offered
//   in_ready   out  1      operation accepted when in_valid && in_ready
//   A, B       in   WIDTH  operands
//   ALU_Sel    in   4      opcode
//   out_valid  out  1      Result/NZVC valid
//   out_ready  in   1      consumer accepts when out_valid && out_ready
//   Result     out  WIDTH  operation result
//   NZVC       out  4      flags {N,Z,V,C} of Result
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       NZVC
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Stage 1 registers
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [3:0]       r_s1_sel;

  // Stage 2 registers
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_nzvc;

`ifdef ALU_CARRY_CHAIN_EN
  logic             r_cq;
`endif

  // Handshake / datapath wires
  logic             w_s1_load;
  logic             w_s1_adv;
  logic [WIDTH-1:0] w_opb;
  logic             w_cin;
  logic             w_is_add;
  logic             w_is_sub;
  logic             w_rsvd;
  logic [WIDTH:0]   w_wide;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic [3:0]       w_nzvc;

  // Stage 1 may move forward whenever stage 2 is empty or is being drained.
  assign w_s1_adv  = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready  = !r_s1_valid || !r_s2_valid || out_ready;
  assign w_s1_load = in_valid && in_ready;

  assign out_valid = r_s2_valid;
  assign Result    = r_result;
  assign NZVC      = r_nzvc;

  // Compute from stage 1 contents. Cq is written on the same edge that moves
  // an op into stage 2, and the next op reads it one cycle later from stage 1,
  // so back-to-back ADC/SBC see the freshly written carry with no bubble.
  always_comb begin
    w_opb    = r_s1_b;
    w_cin    = 1'b0;
    w_is_add = 1'b0;
    w_is_sub = 1'b0;
    w_rsvd   = 1'b0;
    w_wide   = '0;
    w_res    = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;

    case (r_s1_sel)
      4'd0: w_is_add = 1'b1;
      4'd1: begin
        w_is_add = 1'b1;
        w_opb    = ONE;
      end
      4'd2: w_is_sub = 1'b1;
      4'd3: begin
        w_is_sub = 1'b1;
        w_opb    = ONE;
      end
      4'd4: w_res = r_s1_a & r_s1_b;
      4'd5: w_res = r_s1_a | r_s1_b;
      4'd6: w_res = r_s1_a ^ r_s1_b;
      4'd7: w_res = ~r_s1_a;
`ifdef ALU_CARRY_CHAIN_EN
      4'd8: begin
        w_is_add = 1'b1;
        w_cin    = r_cq;
      end
      4'd9: begin
        w_is_sub = 1'b1;
        w_cin    = r_cq;
      end
`endif
      4'd10: begin
        w_res = {r_s1_a[MSB-1:0], 1'b0};
        w_c   = r_s1_a[MSB];
      end
      4'd11: begin
        w_res = {1'b0, r_s1_a[MSB:1]};
        w_c   = r_s1_a[0];
      end
      default: w_rsvd = 1'b1;
    endcase

    // One extra bit catches carry-out for adds; for subtracts the same bit
    // is set exactly when A < subtrahend + borrow-in, i.e. the borrow.
    if (w_is_add) begin
      w_wide = {1'b0, r_s1_a} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_cin};
      w_res  = w_wide[MSB:0];
      w_c    = w_wide[WIDTH];
      w_v    = (r_s1_a[MSB] == w_opb[MSB]) && (w_res[MSB] != r_s1_a[MSB]);
    end else if (w_is_sub) begin
      w_wide = {1'b0, r_s1_a} - {1'b0, w_opb} - {{WIDTH{1'b0}}, w_cin};
      w_res  = w_wide[MSB:0];
      w_c    = w_wide[WIDTH];
      w_v    = (r_s1_a[MSB] != w_opb[MSB]) && (w_res[MSB] != r_s1_a[MSB]);
    end
  end

  assign w_nzvc = w_rsvd ? 4'b0100 : {w_res[MSB], (w_res == '0), w_v, w_c};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_sel   <= '0;
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_nzvc     <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= 1'b1;
        r_s1_a     <= A;
        r_s1_b     <= B;
        r_s1_sel   <= ALU_Sel;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      // Output registers only change when a new op arrives, so they stay
      // stable while the consumer stalls.
      if (w_s1_adv) begin
        r_s2_valid <= 1'b1;
        r_result   <= w_res;
        r_nzvc     <= w_nzvc;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_CARRY_CHAIN_EN
  // Reserved opcodes leave the carry untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cq <= 1'b0;
    end else if (w_s1_adv && !w_rsvd) begin
      r_cq <= w_c;
    end
  end
`endif

endmodule
